sram_seq_ctrl: RTL and testbench
================================

Name: sram_seq_ctrl

Overview:
- Command sequencer sitting between a host request/response port and the serial-load SRAM macro wrapper.
- Converts one parallel write or read request into the macro's strobe sequence:
  - write: MSB-first serial shift, settle cycle, single-cycle write enable;
  - read: single-cycle read enable, then capture on data-valid.
- Returns exactly one response per request, with a timeout flag if the macro never asserts data-valid.

Parameters:
- DATA_WIDTH, 8, SRAM word width (bits shifted per write, width of read data).
- ADDR_WIDTH, 2, SRAM address width.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for sram_data_valid after a read strobe (min 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request present.
- req_ready  output  1  controller idle and able to accept.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  target address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_timeout  output  1  read timed out; qualified by rsp_valid.
- sram_serial_in  output  1  serial data bit to macro.
- sram_shift  output  1  shift strobe to macro.
- sram_w_en  output  1  write enable to macro.
- sram_r_en  output  1  read enable to macro.
- sram_addr  output  ADDR_WIDTH  address to macro.
- sram_data_valid  input  1  macro read data valid.
- sram_data_out  input  DATA_WIDTH  macro read data.

Behaviour:
- Clock and reset: single clock clk. arst_n is asynchronous, active-low; on assertion all state and outputs clear immediately.
- Registered outputs: every output is registered except req_ready, which is decoded from state == IDLE.
- Reset values:
  - state = IDLE;
  - req_ready = 1;
  - rsp_valid, rsp_timeout, sram_serial_in, sram_shift, sram_w_en, sram_r_en = 0;
  - rsp_rdata, sram_addr = 0;
  - bit counter and timeout counter = 0.
- FSM states: IDLE, SHIFT, SETTLE, WRITE, READ, WAIT, RESP.
- Accept:
  - A request is accepted at the rising edge where req_valid && req_ready.
  - req_addr and req_wdata are latched at that edge.
  - sram_addr takes the latched address and is held until the return to IDLE.
  - Request inputs are ignored outside IDLE.
- Write path (cycle k = 1 is the first cycle after the accept edge):
  - k = 1..DATA_WIDTH: state SHIFT, sram_shift = 1, sram_serial_in = wdata[DATA_WIDTH-k], i.e. MSB first.
  - k = DATA_WIDTH+1: state SETTLE, all strobes 0.
  - k = DATA_WIDTH+2: state WRITE, sram_w_en = 1 for exactly one cycle.
  - k = DATA_WIDTH+3: state RESP, rsp_valid = 1, rsp_rdata = 0, rsp_timeout = 0.
  - k = DATA_WIDTH+4: state IDLE, req_ready = 1.
- Read path:
  - k = 1: state READ, sram_r_en = 1.
  - From k = 1 on (READ, then WAIT), sram_data_valid is sampled every edge.
  - First edge with sram_data_valid = 1: capture sram_data_out into rsp_rdata, go to RESP (rsp_valid = 1, rsp_timeout = 0).
  - sram_r_en is low in WAIT.
  - Timeout: if TIMEOUT_CYCLES consecutive samples (READ cycle included) see 0, go to RESP with rsp_timeout = 1, rsp_rdata = 0.
- Response:
  - rsp_valid is a single-cycle pulse; there is no backpressure on the response.
  - rsp_rdata and rsp_timeout hold their values until the next response.
- Strobe exclusivity: sram_shift, sram_w_en and sram_r_en are mutually exclusive and never high in the same cycle.
- Back-to-back requests: a new request is accepted in the first IDLE cycle; there is no zero-bubble overlap with RESP.
- Boundaries:
  - DATA_WIDTH = 1: SHIFT lasts exactly one cycle.
  - sram_data_valid high outside READ/WAIT is ignored.
  - sram_data_valid on the same edge as the timeout expiry counts as valid data, not a timeout.
- Reset mid-operation:
  - Strobes drop immediately and no response is issued.
  - The macro content at the address is undefined if reset lands in SHIFT/SETTLE/WRITE.

Test Plan:
- Reset: hold arst_n = 0 for 2 cycles -> all outputs 0, req_ready = 1; assert arst_n asynchronously mid-cycle during SHIFT -> sram_shift drops before the next edge.
- Write addr = 2'b01, wdata = 8'hA5 -> sram_shift high 8 cycles with serial bits 1,0,1,0,0,1,0,1; one SETTLE cycle; sram_w_en pulse at k = 10; rsp_valid at k = 11; req_ready back at k = 12; sram_addr = 1 throughout.
- Read addr = 2'b01, macro model asserts data_valid 3 cycles after r_en with 8'hA5 -> rsp_valid with rsp_rdata = 8'hA5, rsp_timeout = 0; r_en high exactly 1 cycle.
- Read with data_valid held 0 -> rsp_valid with rsp_timeout = 1, rsp_rdata = 0 exactly TIMEOUT_CYCLES = 16 samples after the accept; data_valid arriving on the 16th sample -> normal data response instead.
- Back-to-back write 8'h3C then read, with req_valid held high -> second accept on the first cycle req_ready = 1; no strobe overlap; read returns 8'h3C from the model.
- Request while busy, and spurious data_valid while IDLE -> no accept and no rsp_valid; DATA_WIDTH = 1 build with write 1'b1 -> one shift cycle, w_en at k = 3.

Source files
------------

// File: rtl/sram_seq_ctrl_if.sv
// Host request/response and SRAM macro strobe bundle for the serial-load SRAM sequencer.
// master drives requests and the macro's read return; slave is the sequencer itself.
interface sram_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic                  sram_serial_in;
    logic                  sram_shift;
    logic                  sram_w_en;
    logic                  sram_r_en;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_data_valid;
    logic [DATA_WIDTH-1:0] sram_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output sram_data_valid, sram_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  sram_serial_in, sram_shift, sram_w_en, sram_r_en, sram_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  sram_data_valid, sram_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output sram_serial_in, sram_shift, sram_w_en, sram_r_en, sram_addr
    );
endinterface

// File: rtl/sram_seq_ctrl.sv
// Sequencer turning one parallel host write/read into the serial-load SRAM macro strobe
// sequence, returning exactly one response (with timeout flag) per accepted request.
module sram_seq_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           arst_n,
    sram_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SETTLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic                  sram_serial_in;
    logic                  sram_shift;
    logic                  sram_w_en;
    logic                  sram_r_en;
    logic [ADDR_WIDTH-1:0] sram_addr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            to_cnt         <= '0;
            shreg          <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_timeout    <= 1'b0;
            sram_serial_in <= 1'b0;
            sram_shift     <= 1'b0;
            sram_w_en      <= 1'b0;
            sram_r_en      <= 1'b0;
            sram_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        sram_addr <= bus.req_addr;
                        if (bus.req_write) begin
                            // First bit goes out now; the remainder waits MSB-aligned in shreg.
                            state          <= SHIFT;
                            sram_shift     <= 1'b1;
                            sram_serial_in <= bus.req_wdata[DATA_WIDTH-1];
                            shreg          <= bus.req_wdata << 1;
                            bit_cnt        <= '0;
                        end else begin
                            state     <= READ;
                            sram_r_en <= 1'b1;
                            to_cnt    <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        state          <= SETTLE;
                        sram_shift     <= 1'b0;
                        sram_serial_in <= 1'b0;
                    end else begin
                        bit_cnt        <= bit_cnt + 1'b1;
                        sram_serial_in <= shreg[DATA_WIDTH-1];
                        shreg          <= shreg << 1;
                    end
                end
                SETTLE: begin
                    state     <= WRITE;
                    sram_w_en <= 1'b1;
                end
                WRITE: begin
                    state       <= RESP;
                    sram_w_en   <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= '0;
                    rsp_timeout <= 1'b0;
                end
                READ, WAIT: begin
                    sram_r_en <= 1'b0;
                    // Valid data wins over a timeout expiring on the same edge.
                    if (bus.sram_data_valid) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= bus.sram_data_out;
                        rsp_timeout <= 1'b0;
                    end else if (to_cnt == LAST_TO) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        state  <= WAIT;
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_rdata      = rsp_rdata;
    assign bus.rsp_timeout    = rsp_timeout;
    assign bus.sram_serial_in = sram_serial_in;
    assign bus.sram_shift     = sram_shift;
    assign bus.sram_w_en      = sram_w_en;
    assign bus.sram_r_en      = sram_r_en;
    assign bus.sram_addr      = sram_addr;
endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Directed bench for sram_seq_ctrl: 8-bit instance with a small macro model, plus a 1-bit build.
module tb_sram_seq_ctrl;
    logic clk;
    logic arst_n;
    int   total;
    int   bad;

    sram_seq_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();
    sram_seq_ctrl_if #(.DATA_WIDTH(1), .ADDR_WIDTH(2)) bus1 ();

    sram_seq_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    sram_seq_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(16)) dut1 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: serial load, write on w_en, data valid three cycles after r_en.
    logic       model_en;
    logic       tb_dv;
    logic [7:0] tb_dout;
    logic [7:0] m_sreg;
    logic [7:0] mem [4];
    logic       rp1, rp2, m_dv;
    logic [7:0] m_dout;

    always @(posedge clk) begin
        if (bus.sram_shift) m_sreg <= {m_sreg[6:0], bus.sram_serial_in};
        if (bus.sram_w_en) mem[bus.sram_addr] <= m_sreg;
        rp1    <= bus.sram_r_en;
        rp2    <= rp1;
        m_dv   <= rp2;
        m_dout <= mem[bus.sram_addr];
    end

    assign bus.sram_data_valid  = model_en ? m_dv : tb_dv;
    assign bus.sram_data_out    = model_en ? m_dout : tb_dout;
    assign bus1.sram_data_valid = 1'b0;
    assign bus1.sram_data_out   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] wd;
        total    = 0;
        bad      = 0;
        arst_n   = 1'b0;
        model_en = 1'b0;
        tb_dv    = 1'b0;
        tb_dout  = 8'h00;
        m_sreg   = 8'h00;
        rp1      = 1'b0;
        rp2      = 1'b0;
        m_dv     = 1'b0;
        m_dout   = 8'h00;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 2'd0;
        bus.req_wdata  = 8'h00;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = 2'd0;
        bus1.req_wdata = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_outs", 32'({bus.rsp_valid, bus.rsp_timeout, bus.sram_serial_in,
                             bus.sram_shift, bus.sram_w_en, bus.sram_r_en}), 0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_addr", 32'(bus.sram_addr), 0);
        chk("rst_ready_dw1", 32'(bus1.req_ready), 1);
        arst_n = 1'b1;
        tick();

        // Write A5 to address 1, with a read request presented while busy
        wd = 8'hA5;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 2'd1;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b0;
                bus.req_addr  = 2'd2;
            end
            if (k == 6) bus.req_valid = 1'b0;
            chk($sformatf("wr_shift_k%0d", k), 32'(bus.sram_shift), 1);
            chk($sformatf("wr_bit_k%0d", k), 32'(bus.sram_serial_in), 32'(wd[8-k]));
            chk($sformatf("wr_addr_k%0d", k), 32'(bus.sram_addr), 1);
            chk($sformatf("wr_other_k%0d", k), 32'({bus.sram_w_en, bus.sram_r_en, bus.req_ready}), 0);
            tick();
        end
        chk("wr_settle", 32'({bus.sram_shift, bus.sram_w_en, bus.sram_r_en, bus.req_ready}), 0);
        tick();
        chk("wr_wen_k10", 32'({bus.sram_shift, bus.sram_w_en, bus.sram_r_en}), 3'b010);
        chk("wr_addr_k10", 32'(bus.sram_addr), 1);
        tick();
        chk("wr_wen_k11", 32'(bus.sram_w_en), 0);
        chk("wr_rsp_k11", 32'({bus.rsp_valid, bus.rsp_timeout, bus.req_ready}), 3'b100);
        chk("wr_rdata_k11", 32'(bus.rsp_rdata), 0);
        tick();
        chk("wr_idle_k12", 32'({bus.rsp_valid, bus.req_ready}), 2'b01);

        // Spurious data valid while idle
        tb_dv   = 1'b1;
        tb_dout = 8'h77;
        tick();
        tick();
        chk("spur_rsp", 32'({bus.rsp_valid, bus.req_ready, bus.sram_r_en}), 3'b010);
        chk("spur_rdata", 32'(bus.rsp_rdata), 0);
        tb_dv = 1'b0;
        tick();

        // Read address 1, data valid three cycles after the r_en cycle
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 2'd1;
        tick();
        bus.req_valid = 1'b0;
        chk("rd_ren_k1", 32'({bus.sram_shift, bus.sram_w_en, bus.sram_r_en}), 3'b001);
        chk("rd_addr_k1", 32'(bus.sram_addr), 1);
        tick();
        chk("rd_ren_k2", 32'(bus.sram_r_en), 0);
        tick();
        tick();
        tb_dv   = 1'b1;
        tb_dout = 8'hA5;
        chk("rd_norsp_k4", 32'({bus.rsp_valid, bus.sram_r_en}), 0);
        tick();
        tb_dv   = 1'b0;
        tb_dout = 8'h00;
        chk("rd_rsp_k5", 32'({bus.rsp_valid, bus.rsp_timeout}), 2'b10);
        chk("rd_rdata_k5", 32'(bus.rsp_rdata), 32'h A5);
        tick();
        chk("rd_idle_k6", 32'({bus.rsp_valid, bus.req_ready}), 2'b01);
        chk("rd_hold_k6", 32'(bus.rsp_rdata), 32'hA5);

        // Read with data valid never asserted
        bus.req_valid = 1'b1;
        bus.req_addr  = 2'd3;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        chk("to_norsp_k16", 32'(bus.rsp_valid), 0);
        tick();
        chk("to_rsp_k17", 32'({bus.rsp_valid, bus.rsp_timeout}), 2'b11);
        chk("to_rdata_k17", 32'(bus.rsp_rdata), 0);
        tick();
        chk("to_idle_k18", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_timeout}), 3'b011);

        // Data valid on the sixteenth sample beats the timeout
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        tb_dv   = 1'b1;
        tb_dout = 8'h5A;
        tick();
        tb_dv   = 1'b0;
        tb_dout = 8'h00;
        chk("edge_rsp_k17", 32'({bus.rsp_valid, bus.rsp_timeout}), 2'b10);
        chk("edge_rdata_k17", 32'(bus.rsp_rdata), 32'h5A);
        tick();

        // Back-to-back write 3C then read with req_valid held high
        model_en = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 2'd2;
        bus.req_wdata = 8'h3C;
        tick();
        bus.req_write = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("b2b_excl_k%0d", k),
                32'($countones({bus.sram_shift, bus.sram_w_en, bus.sram_r_en}) <= 1), 1);
            chk($sformatf("b2b_busy_k%0d", k), 32'(bus.req_ready), 0);
            tick();
        end
        chk("b2b_ready_k12", 32'({bus.req_ready, bus.sram_r_en}), 2'b10);
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_ren", 32'({bus.sram_shift, bus.sram_w_en, bus.sram_r_en}), 3'b001);
        chk("b2b_addr", 32'(bus.sram_addr), 2);
        tick();
        tick();
        tick();
        chk("b2b_norsp", 32'(bus.rsp_valid), 0);
        tick();
        chk("b2b_rsp", 32'({bus.rsp_valid, bus.rsp_timeout}), 2'b10);
        chk("b2b_rdata", 32'(bus.rsp_rdata), 32'h3C);
        tick();
        model_en = 1'b0;

        // Asynchronous reset landing mid-cycle during SHIFT
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 2'd3;
        bus.req_wdata = 8'hFF;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("arst_pre_shift", 32'(bus.sram_shift), 1);
        #3;
        arst_n = 1'b0;
        #1;
        chk("arst_shift_drop", 32'({bus.sram_shift, bus.sram_serial_in}), 0);
        chk("arst_ready", 32'(bus.req_ready), 1);
        chk("arst_addr", 32'(bus.sram_addr), 0);
        tick();
        arst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("arst_norsp_%0d", k), 32'({bus.rsp_valid, bus.sram_w_en}), 0);
            tick();
        end

        // One-bit build: write 1
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_addr  = 2'd3;
        bus1.req_wdata = 1'b1;
        tick();
        bus1.req_valid = 1'b0;
        chk("dw1_shift_k1", 32'({bus1.sram_shift, bus1.sram_serial_in, bus1.sram_w_en}), 3'b110);
        tick();
        chk("dw1_settle_k2", 32'({bus1.sram_shift, bus1.sram_w_en, bus1.rsp_valid}), 0);
        tick();
        chk("dw1_wen_k3", 32'({bus1.sram_shift, bus1.sram_w_en}), 2'b01);
        chk("dw1_addr_k3", 32'(bus1.sram_addr), 3);
        tick();
        chk("dw1_rsp_k4", 32'({bus1.rsp_valid, bus1.rsp_timeout, bus1.sram_w_en}), 3'b100);
        tick();
        chk("dw1_idle_k5", 32'({bus1.rsp_valid, bus1.req_ready}), 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
